// File: rtl/noise_stats_if.sv
// Bundle of the noise stream, window control and held result signals of the
// noise statistics monitor.
interface noise_stats_if #(
   parameter int NOISE_IN_BITS = 15,
   parameter int WINDOW_BITS   = 20
);
   logic [NOISE_IN_BITS-1:0]               noise_in;
   logic                                   noise_valid;
   logic                                   start;
   logic [WINDOW_BITS-1:0]                 window_len;
   logic                                   busy;
   logic                                   done;
   logic [WINDOW_BITS-1:0]                 sample_count;
   logic [NOISE_IN_BITS+WINDOW_BITS-1:0]   sum_out;
   logic [2*NOISE_IN_BITS+WINDOW_BITS-1:0] sumsq_out;
   logic [NOISE_IN_BITS-1:0]               min_out;
   logic [NOISE_IN_BITS-1:0]               max_out;
   logic [WINDOW_BITS-1:0]                 outlier_count;

   modport master (
      output noise_in, noise_valid, start, window_len,
      input  busy, done, sample_count, sum_out, sumsq_out, min_out, max_out, outlier_count
   );

   modport slave (
      input  noise_in, noise_valid, start, window_len,
      output busy, done, sample_count, sum_out, sumsq_out, min_out, max_out, outlier_count
   );
endinterface

// File: rtl/noise_stats_monitor.sv
// Windowed statistics (count, sum, sum of squares, min, max, outliers) over a
// signed noise stream; results are held stable between done pulses.
module noise_stats_monitor #(
   parameter int NOISE_IN_BITS  = 15,
   parameter int WINDOW_BITS    = 20,
   parameter int OUTLIER_THRESH = 8
) (
   input logic          clk,
   input logic          rst,
   noise_stats_if.slave bus
);
   localparam int SUM_W   = NOISE_IN_BITS + WINDOW_BITS;
   localparam int SQ_W    = 2 * NOISE_IN_BITS;
   localparam int SUMSQ_W = SQ_W + WINDOW_BITS;
   localparam logic signed [NOISE_IN_BITS:0] THRESH = (NOISE_IN_BITS+1)'(OUTLIER_THRESH);

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
   state_t state_reg, state_next;

   logic [WINDOW_BITS-1:0]          win_len_reg, count_reg, outl_reg;
   logic signed [SUM_W-1:0]         sum_reg;
   logic [SUMSQ_W-1:0]              sumsq_reg;
   logic signed [NOISE_IN_BITS-1:0] min_reg, max_reg;
   logic                            first_reg;
   logic [SQ_W-1:0]                 sq_reg;
   logic                            sq_valid_reg;

   logic [WINDOW_BITS-1:0]          res_count_reg, res_outl_reg;
   logic signed [SUM_W-1:0]         res_sum_reg;
   logic [SUMSQ_W-1:0]              res_sumsq_reg;
   logic signed [NOISE_IN_BITS-1:0] res_min_reg, res_max_reg;
   logic                            done_reg;

   logic signed [NOISE_IN_BITS-1:0] x;
   logic signed [NOISE_IN_BITS:0]   x_ext;
   logic signed [SQ_W-1:0]          x_sq;
   logic [WINDOW_BITS-1:0]          count_inc;
   logic [SUMSQ_W-1:0]              sumsq_final;
   logic                            start_ok, accept, outlier, zero_len;

   assign x           = $signed(bus.noise_in);
   assign x_ext       = {x[NOISE_IN_BITS-1], x};
   assign x_sq        = x * x;
   assign count_inc   = count_reg + WINDOW_BITS'(1);
   assign outlier     = (x_ext > THRESH) || (x_ext < -THRESH);
   assign zero_len    = (bus.window_len == '0);
   // The pending square from the previous accepted sample lands here.
   assign sumsq_final = sumsq_reg + (sq_valid_reg ? SUMSQ_W'(sq_reg) : '0);

   always_comb begin
      state_next = state_reg;
      start_ok   = 1'b0;
      accept     = 1'b0;
      case (state_reg)
         IDLE, DONE: begin
            if (bus.start) begin
               start_ok   = 1'b1;
               state_next = zero_len ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (bus.noise_valid) begin
               accept = 1'b1;
               if (count_inc == win_len_reg) state_next = DRAIN;
            end
         end
         DRAIN:   state_next = DONE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         win_len_reg   <= '0;
         count_reg     <= '0;
         outl_reg      <= '0;
         sum_reg       <= '0;
         sumsq_reg     <= '0;
         min_reg       <= '0;
         max_reg       <= '0;
         first_reg     <= 1'b0;
         sq_reg        <= '0;
         sq_valid_reg  <= 1'b0;
         res_count_reg <= '0;
         res_outl_reg  <= '0;
         res_sum_reg   <= '0;
         res_sumsq_reg <= '0;
         res_min_reg   <= '0;
         res_max_reg   <= '0;
         done_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         done_reg     <= 1'b0;
         sq_valid_reg <= accept;
         if (accept) sq_reg <= $unsigned(x_sq);

         if (start_ok) begin
            win_len_reg <= bus.window_len;
            count_reg   <= '0;
            outl_reg    <= '0;
            sum_reg     <= '0;
            sumsq_reg   <= '0;
            min_reg     <= '0;
            max_reg     <= '0;
            first_reg   <= 1'b1;
            if (zero_len) begin
               done_reg      <= 1'b1;
               res_count_reg <= '0;
               res_outl_reg  <= '0;
               res_sum_reg   <= '0;
               res_sumsq_reg <= '0;
               res_min_reg   <= '0;
               res_max_reg   <= '0;
            end
         end else begin
            sumsq_reg <= sumsq_final;
            if (accept) begin
               count_reg <= count_inc;
               sum_reg   <= sum_reg + $signed({{WINDOW_BITS{x[NOISE_IN_BITS-1]}}, x});
               first_reg <= 1'b0;
               if (outlier) outl_reg <= outl_reg + WINDOW_BITS'(1);
               if (first_reg || (x < min_reg)) min_reg <= x;
               if (first_reg || (x > max_reg)) max_reg <= x;
            end
         end

         if (state_reg == DRAIN) begin
            done_reg      <= 1'b1;
            res_count_reg <= count_reg;
            res_outl_reg  <= outl_reg;
            res_sum_reg   <= sum_reg;
            res_sumsq_reg <= sumsq_final;
            res_min_reg   <= min_reg;
            res_max_reg   <= max_reg;
         end
      end
   end

   assign bus.busy          = (state_reg == ACCUM) || (state_reg == DRAIN);
   assign bus.done          = done_reg;
   assign bus.sample_count  = res_count_reg;
   assign bus.sum_out       = res_sum_reg;
   assign bus.sumsq_out     = res_sumsq_reg;
   assign bus.min_out       = res_min_reg;
   assign bus.max_out       = res_max_reg;
   assign bus.outlier_count = res_outl_reg;
endmodule

// File: tb/tb_noise_stats_monitor.sv
// Bench for noise_stats_monitor: a window-level reference model checked every
// cycle, plus directed windows with hand-computed results and random traffic.
module tb_noise_stats_monitor;
   localparam int NB = 15;
   localparam int WB = 20;
   localparam int TH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_done_seen = 0;

   noise_stats_if #(.NOISE_IN_BITS(NB), .WINDOW_BITS(WB)) bus();

   noise_stats_monitor #(.NOISE_IN_BITS(NB), .WINDOW_BITS(WB), .OUTLIER_THRESH(TH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model: phase 0 = not measuring, 1 = collecting, 2 = last sample taken
   int     m_phase = 0;
   int     m_len   = 0;
   int     m_q[$];
   bit     m_busy  = 1'b0;
   bit     m_done  = 1'b0;
   int     m_count = 0;
   longint m_sum   = 0;
   longint m_sumsq = 0;
   int     m_min   = 0;
   int     m_max   = 0;
   int     m_outl  = 0;

   task automatic publish();
      m_count = m_q.size();
      m_sum = 0; m_sumsq = 0; m_outl = 0; m_min = 0; m_max = 0;
      foreach (m_q[i]) begin
         m_sum   += m_q[i];
         m_sumsq += longint'(m_q[i]) * longint'(m_q[i]);
         if (m_q[i] > TH || m_q[i] < -TH) m_outl++;
         if (i == 0 || m_q[i] < m_min) m_min = m_q[i];
         if (i == 0 || m_q[i] > m_max) m_max = m_q[i];
      end
   endtask

   always @(posedge clk) begin
      m_done = 1'b0;
      if (rst) begin
         m_phase = 0;
         m_q.delete();
         publish();
      end else begin
         case (m_phase)
            0: if (bus.start) begin
               m_len = int'(bus.window_len);
               m_q.delete();
               if (m_len == 0) begin
                  publish();
                  m_done = 1'b1;
               end else m_phase = 1;
            end
            1: if (bus.noise_valid) begin
               m_q.push_back(int'($signed(bus.noise_in)));
               if (m_q.size() == m_len) m_phase = 2;
            end
            default: begin
               publish();
               m_done  = 1'b1;
               m_phase = 0;
            end
         endcase
      end
      m_busy = (m_phase != 0);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (bus.done === 1'b1) n_done_seen++;
      chk("busy",    64'(bus.busy), 64'(m_busy));
      chk("done",    64'(bus.done), 64'(m_done));
      chk("count",   64'(bus.sample_count), 64'(m_count[WB-1:0]));
      chk("sum",     64'(bus.sum_out), 64'(m_sum[NB+WB-1:0]));
      chk("sumsq",   64'(bus.sumsq_out), 64'(m_sumsq[2*NB+WB-1:0]));
      chk("min",     64'(bus.min_out), 64'(m_min[NB-1:0]));
      chk("max",     64'(bus.max_out), 64'(m_max[NB-1:0]));
      chk("outlier", 64'(bus.outlier_count), 64'(m_outl[WB-1:0]));
   end

   task automatic drive(input bit st, input bit v, input int x, input int len);
      @(negedge clk);
      bus.start       = st;
      bus.noise_valid = v;
      bus.noise_in    = x[NB-1:0];
      bus.window_len  = len[WB-1:0];
   endtask

   task automatic pulse_rst();
      @(negedge clk);
      rst = 1'b1;
      bus.start = 1'b0;
      bus.noise_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Waits (bounded) for done and pins the held results to literal values.
   task automatic expect_done(input string tag, input int lat, input int cnt, input longint sum,
                              input longint sumsq, input int mn, input int mx, input int outl);
      int k;
      k = 0;
      for (int i = 1; i <= 20; i++) begin
         drive(1'b0, 1'b0, 0, 0);
         if (bus.done === 1'b1) begin
            k = i;
            break;
         end
      end
      chk({tag, "_latency"}, 64'(k), 64'(lat));
      chk({tag, "_count"},   64'(bus.sample_count), 64'(cnt[WB-1:0]));
      chk({tag, "_sum"},     64'(bus.sum_out), 64'(sum[NB+WB-1:0]));
      chk({tag, "_sumsq"},   64'(bus.sumsq_out), 64'(sumsq[2*NB+WB-1:0]));
      chk({tag, "_min"},     64'(bus.min_out), 64'(mn[NB-1:0]));
      chk({tag, "_max"},     64'(bus.max_out), 64'(mx[NB-1:0]));
      chk({tag, "_outlier"}, 64'(bus.outlier_count), 64'(outl[WB-1:0]));
      $display("window %s: latency=%0d count=%0d sum=%0d sumsq=%0d", tag, k,
               bus.sample_count, $signed(bus.sum_out), bus.sumsq_out);
   endtask

   function automatic int rand_sample();
      int sel;
      if ($urandom_range(0, 9) == 0) begin
         sel = int'($urandom_range(0, 5));
         case (sel)
            0: return -16384;
            1: return 16383;
            2: return TH;
            3: return -TH;
            4: return TH + 1;
            default: return -TH - 1;
         endcase
      end
      return int'($urandom_range(0, 40)) - 20;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int len;
      bus.start = 1'b0;
      bus.noise_valid = 1'b0;
      bus.noise_in = '0;
      bus.window_len = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) drive(1'b0, 1'($urandom_range(0, 1)), rand_sample(), 0);
      chk("idle_no_done", 64'(n_done_seen), 64'(0));
      chk("idle_busy", 64'(bus.busy), 64'(0));

      drive(1'b1, 1'b0, 0, 4);
      drive(1'b0, 1'b1, 3, 0);
      drive(1'b0, 1'b0, 99, 0);
      drive(1'b0, 1'b1, -5, 0);
      drive(1'b0, 1'b1, 10, 0);
      drive(1'b0, 1'b0, 77, 0);
      drive(1'b0, 1'b1, 0, 0);
      expect_done("w4", 2, 4, 8, 134, -5, 10, 1);

      drive(1'b1, 1'b0, 0, 1);
      drive(1'b0, 1'b1, -16384, 0);
      expect_done("w1_neg", 2, 1, -16384, 268435456, -16384, -16384, 1);

      drive(1'b1, 1'b0, 0, 3);
      drive(1'b0, 1'b1, 1, 0);
      drive(1'b1, 1'b1, 1, 7);
      chk("hold_sum", 64'(bus.sum_out), 64'(35'h7_ffff_c000));
      drive(1'b0, 1'b1, 1, 0);
      drive(1'b0, 1'b1, 1, 0);
      expect_done("w3_restart", 1, 3, 3, 3, 1, 1, 0);

      drive(1'b1, 1'b1, 5, 0);
      expect_done("w0", 1, 0, 0, 0, 0, 0, 0);

      drive(1'b1, 1'b0, 0, 5);
      drive(1'b0, 1'b1, 1000, 0);
      drive(1'b0, 1'b1, -1000, 0);
      pulse_rst();
      chk("rst_busy", 64'(bus.busy), 64'(0));
      drive(1'b1, 1'b0, 0, 2);
      drive(1'b0, 1'b1, 7, 0);
      drive(1'b0, 1'b1, 7, 0);
      expect_done("w2_after_rst", 2, 2, 14, 98, 7, 7, 0);

      for (int w = 0; w < 25; w++) begin
         len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 30));
         drive(1'b1, 1'($urandom_range(0, 1)), rand_sample(), len);
         for (int c = 0; c < 60; c++) begin
            if ($urandom_range(0, 199) == 0) pulse_rst();
            else drive(($urandom_range(0, 29) == 0), ($urandom_range(0, 9) < 7),
                       rand_sample(), int'($urandom_range(0, 40)));
         end
         $display("random window %0d: len=%0d done_seen=%0d", w, len, n_done_seen);
      end

      repeat (3) drive(1'b0, 1'b0, 0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/noise_stats_monitor.md
Name: noise_stats_monitor

Overview:
- Receiving end of the simulator's noise sample stream; sits downstream of the noise generator, or on any signed noise/ADC-like stream.
- Over a programmable window of valid samples it accumulates count, sum, sum of squares, min, max and an outlier count (|x| > threshold).
- Results are held stable for HPS/bridge readout, allowing on-FPGA validation of the generated noise distribution.

Parameters:
- NOISE_IN_BITS, 15, width of the signed input sample.
- WINDOW_BITS, 20, width of the window-length field; maximum window 2^WINDOW_BITS-1 samples.
- OUTLIER_THRESH, 8, non-negative magnitude threshold; sample is an outlier if x > OUTLIER_THRESH or x < -OUTLIER_THRESH.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- noise_in  in  NOISE_IN_BITS  signed sample.
- noise_valid  in  1  noise_in is valid this cycle.
- start  in  1  begin a new measurement window (single-cycle pulse).
- window_len  in  WINDOW_BITS  number of samples to accumulate; sampled on the accepted start.
- busy  out  1  measurement in progress (ACCUM or DRAIN).
- done  out  1  one-cycle pulse when results become valid.
- sample_count  out  WINDOW_BITS  samples accepted in the last window.
- sum_out  out  NOISE_IN_BITS+WINDOW_BITS  signed sum.
- sumsq_out  out  2*NOISE_IN_BITS+WINDOW_BITS  unsigned sum of squares.
- min_out  out  NOISE_IN_BITS  signed minimum.
- max_out  out  NOISE_IN_BITS  signed maximum.
- outlier_count  out  WINDOW_BITS  number of outlier samples.

Behaviour:
- Reset: state IDLE; busy=0, done=0; all result outputs and internal accumulators = 0.
- FSM states: IDLE, ACCUM, DRAIN, DONE.
- IDLE/DONE + start:
  - Latch window_len; clear accumulators and counters; arm the first-sample flag.
  - If window_len==0: go directly to DONE next cycle with done=1 and all results 0.
  - Otherwise go to ACCUM.
- ACCUM:
  - Each cycle with noise_valid=1 accepts one sample; noise_valid=0 cycles are ignored.
  - On acceptance:
    - count+1; sum += sign-extended x.
    - min/max: the first sample loads both; later samples compare signed.
    - Outlier counter +1 if x outside [-OUTLIER_THRESH, +OUTLIER_THRESH].
    - x*x is registered in a pipeline stage and added to sumsq on the following cycle.
  - When the accepted sample makes count == latched window_len, move to DRAIN.
  - Samples presented after that are ignored.
- DRAIN:
  - One cycle; the final pending square is added.
  - Next state DONE.
- DONE:
  - On entry, done=1 for exactly one cycle; result outputs update in that same cycle and then hold.
  - busy=0.
  - Remains in DONE until start.
- Latency: last sample accepted in cycle T -> DRAIN at T+1 -> done=1 and results valid at T+2.
- busy=1 in ACCUM and DRAIN only.
- Result outputs change only on the done cycle, or go to 0 on rst. A new start does not clear visible results until its own done.
- start during ACCUM/DRAIN is ignored; window_len changes after the accepted start have no effect.
- start and noise_valid in the same cycle as IDLE->ACCUM: that sample is NOT accepted. Accumulation begins the following cycle.
- Arithmetic:
  - Squares are computed from the signed input; result width 2*NOISE_IN_BITS, always non-negative.
  - Accumulator widths are sized for the maximum window, so no overflow and no saturation is required.
  - -2^(NOISE_IN_BITS-1) is handled correctly: its square is 2^(2*NOISE_IN_BITS-2), and it counts as an outlier.
- rst in any state: returns to IDLE next cycle, discards the partial window and the pending square, clears outputs.

Test Plan:
- Reset, then idle 10 cycles with random noise_valid -> busy=0, done never asserted, all outputs 0.
- start with window_len=4; samples 3, -5, 10, 0 with gaps in noise_valid -> done 2 cycles after the 4th sample; sample_count=4, sum=8, sumsq=134, min=-5, max=10, outlier_count=1.
- start with window_len=1, sample -16384 -> sum=-16384, sumsq=268435456, min=max=-16384, outlier_count=1.
- start with window_len=0 -> done one cycle later, all results 0, busy never asserted.
- window_len=3; second start pulsed mid-window; samples 1, 1, 1, 1 -> single done, count=3, sum=3, sumsq=3. Previous results stay visible until this done.
- window_len=5; rst after 2 samples, then start with window_len=2 and samples 7, 7 -> sum=14, sumsq=98, min=max=7; no stale data from the aborted window.
